pkt_seg_fifo: RTL and testbench
===============================

// Module: pkt_seg_fifo
// PURPOSE
//   Packet-segment buffer feeding the deparser. Accepts the AXI-Stream packet from the
//   parser side (256b segments + tkeep/tuser/tlast) and holds it while the PHV is processed.
//   Presents it first-word-fall-through (FWFT) on the pkt_fifo_* interface the deparser
//   consumes. Tracks complete stored packets so the consumer can tell a whole packet is buffered.
// PARAMETERS
//   C_AXIS_DATA_WIDTH   256  segment data width (bits)
//   C_AXIS_TUSER_WIDTH  128  tuser width carried alongside each segment
//   C_DEPTH_LOG2        6    log2 of segment entries (depth 64); power-of-two depth only
//   C_AFULL_THRESH      60   fifo_count >= this asserts fifo_almost_full
// PORTS
//   clk                input   1        single clock domain
//   areset             input   1        asynchronous, active-high reset
//   s_axis_tdata       input   DW       ingress segment data
//   s_axis_tkeep       input   DW/8     ingress byte enables
//   s_axis_tuser       input   UW       ingress metadata
//   s_axis_tvalid      input   1        ingress segment valid
//   s_axis_tlast       input   1        last segment of packet
//   s_axis_tready      output  1        1 = segment accepted this cycle if tvalid
//   pkt_fifo_tdata     output  DW       head segment data (FWFT)
//   pkt_fifo_tkeep     output  DW/8     head segment tkeep
//   pkt_fifo_tuser     output  UW       head segment tuser
//   pkt_fifo_tlast     output  1        head segment tlast
//   pkt_fifo_empty     output  1        1 = no segment at head; head outputs invalid
//   pkt_fifo_rd_en     input   1        pop head segment at this clock edge
//   fifo_count         output  L2+1     stored segments, 0..2^L2
//   pkt_count          output  L2+1     stored segments with tlast=1 (complete packets)
//   fifo_almost_full   output  1        fifo_count >= C_AFULL_THRESH
//   rd_underflow       output  1        sticky: rd_en seen while empty
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - wr_ptr, rd_ptr, fifo_count, pkt_count = 0; pkt_fifo_empty = 1.
//   - s_axis_tready = 0 while areset = 1; rd_underflow = 0; head outputs = 0.
//   - Memory contents are not reset. A reset mid-packet discards all stored and partial packets.
// - Storage: 2^L2 entries of {tlast, tuser, tkeep, tdata}. Pointers are L2 bits and wrap
//   modulo depth. fifo_count is held as a separate L2+1-bit counter.
// - Write: s_axis_tready = !full, where full = (fifo_count == 2^L2), computed from registered
//   state only (no same-cycle read bypass at full).
//   - Push when tvalid & tready: mem[wr_ptr] <= segment; wr_ptr++.
// - Read: pop when pkt_fifo_rd_en & !pkt_fifo_empty; rd_ptr++.
//   - rd_en while empty is ignored and sets rd_underflow (held until reset).
// - FWFT head: head outputs = mem[rd_ptr] when !empty, else forced 0.
//   - pkt_fifo_empty = (fifo_count == 0), registered.
//   - Write-to-visible latency: 1 cycle. A segment pushed at edge N is at the head, with
//     empty = 0, after edge N.
// - Simultaneous push & pop (non-empty, non-full): fifo_count unchanged, both pointers advance.
// - Simultaneous push & pop when empty: the push is accepted and the pop is an underflow.
//   fifo_count becomes 1.
// - pkt_count: +1 on push of a tlast segment, -1 on pop of a tlast segment, unchanged when
//   both happen in the same cycle.
//   - Invariant: pkt_count <= fifo_count.
//   - A packet longer than the depth stalls the input with pkt_count = 0. The consumer must
//     not wait for pkt_count > 0 in that case.
// - fifo_almost_full: combinational compare on the registered fifo_count.
// - No drops. Backpressure is the only flow control. tkeep and tuser pass through unmodified.
// TESTING
// - Reset: hold areset 3 cycles -> tready=0, empty=1, counts=0. Release -> tready=1 next cycle.
// - Single packet: push 3 segments (tlast on 3rd), no reads.
//   - Response: fifo_count=3, pkt_count=1. Head = seg0 one cycle after its push.
//   - Three rd_en pops return seg0..seg2 in order; then empty=1 and pkt_count=0.
// - Fill: push 64 non-last segments with no reads.
//   - Response: tready=0 at count 64; almost_full from count 60; the 65th tvalid is held, not accepted.
//   - Pop one -> tready=1 next cycle.
// - Concurrent push/pop at count 10 for 100 cycles: fifo_count stays 10, data order is
//   preserved, pointers wrap with no loss.
// - Underflow: rd_en=1 while empty -> rd_underflow=1 sticky, counts unchanged.
//   Push+pop same cycle when empty -> count=1.
// - Mid-packet reset: push 2 of 4 segments, assert areset -> all counts 0, empty=1.
//   A fresh 1-segment tlast packet then reads back correctly.

Source files
------------

// File: rtl/pkt_seg_fifo.sv
// pkt_seg_fifo
//   Packet-segment buffer that sits in front of the deparser. It takes AXI-Stream
//   segments from the parser side, stores them, and presents them to the deparser
//   first-word-fall-through. It also counts how many complete packets are stored.
//
// Ports
//   clk, areset                  single clock, asynchronous active-high reset
//   s_axis_t{data,keep,user}     ingress segment payload
//   s_axis_tvalid/tlast/tready   ingress handshake and end-of-packet marker
//   pkt_fifo_t{data,keep,user,last}  head segment, forced to 0 while empty
//   pkt_fifo_empty               1 = no segment at the head
//   pkt_fifo_rd_en               pop the head segment at this edge
//   fifo_count                   stored segments, 0..2^C_DEPTH_LOG2
//   pkt_count                    stored segments that carry tlast
//   fifo_almost_full             fifo_count >= C_AFULL_THRESH
//   rd_underflow                 sticky, rd_en seen while empty
module pkt_seg_fifo #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2       = 6,
  parameter int C_AFULL_THRESH     = 60
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
  output logic                            pkt_fifo_tlast,
  output logic                            pkt_fifo_empty,
  input  logic                            pkt_fifo_rd_en,
  output logic [C_DEPTH_LOG2:0]           fifo_count,
  output logic [C_DEPTH_LOG2:0]           pkt_count,
  output logic                            fifo_almost_full,
  output logic                            rd_underflow
);

  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int KW    = C_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int L2    = C_DEPTH_LOG2;
  localparam int EW    = 1 + UW + KW + DW;
  localparam int DEPTH = 1 << L2;
  localparam logic [L2:0] FULL_CNT  = (L2+1)'(DEPTH);
  localparam logic [L2:0] AFULL_CNT = (L2+1)'(C_AFULL_THRESH);
  localparam logic [L2:0] CNT_ONE   = (L2+1)'(1);
  localparam logic [L2-1:0] PTR_ONE = L2'(1);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [L2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [L2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [L2:0]     cnt_q, cnt_d;
  logic [L2:0]     pkt_q, pkt_d;
  logic            empty_q, empty_d;
  logic            uf_q, uf_d;
  logic            rdy_en_q;
  logic            full, push, pop, pkt_inc, pkt_dec;
  logic [EW-1:0]   head_w, head_vis;

  // rdy_en_q holds tready low while reset is asserted and for the first edge
  // after release, so the ingress side sees a clean synchronous start.
  assign full          = (cnt_q == FULL_CNT);
  assign s_axis_tready = rdy_en_q & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = pkt_fifo_rd_en & ~empty_q;

  assign head_w   = mem_q[rd_ptr_q];
  assign head_vis = empty_q ? '0 : head_w;
  assign pkt_inc  = push & s_axis_tlast;
  assign pkt_dec  = pop & head_w[EW-1];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (pkt_inc && !pkt_dec)      pkt_d = pkt_q + CNT_ONE;
    else if (pkt_dec && !pkt_inc) pkt_d = pkt_q - CNT_ONE;
    empty_d = (cnt_d == '0);
    uf_d    = uf_q | (pkt_fifo_rd_en & empty_q);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      empty_q  <= 1'b1;
      uf_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      empty_q  <= empty_d;
      uf_q     <= uf_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  end

  assign pkt_fifo_tdata   = head_vis[DW-1:0];
  assign pkt_fifo_tkeep   = head_vis[DW+KW-1:DW];
  assign pkt_fifo_tuser   = head_vis[DW+KW+UW-1:DW+KW];
  assign pkt_fifo_tlast   = head_vis[EW-1];
  assign pkt_fifo_empty   = empty_q;
  assign fifo_count       = cnt_q;
  assign pkt_count        = pkt_q;
  assign fifo_almost_full = (cnt_q >= AFULL_CNT);
  assign rd_underflow     = uf_q;

endmodule

// File: tb/tb_pkt_seg_fifo.sv
module tb_pkt_seg_fifo;

  localparam int DEPTH = 64;
  localparam int AFULL = 60;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  keep;
    logic [255:0] data;
  } seg_t;

  logic         clk;
  logic         areset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] pkt_fifo_tdata;
  logic [31:0]  pkt_fifo_tkeep;
  logic [127:0] pkt_fifo_tuser;
  logic         pkt_fifo_tlast;
  logic         pkt_fifo_empty;
  logic         pkt_fifo_rd_en;
  logic [6:0]   fifo_count;
  logic [6:0]   pkt_count;
  logic         fifo_almost_full;
  logic         rd_underflow;

  pkt_seg_fifo dut (
    .clk              (clk),
    .areset           (areset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .pkt_fifo_tdata   (pkt_fifo_tdata),
    .pkt_fifo_tkeep   (pkt_fifo_tkeep),
    .pkt_fifo_tuser   (pkt_fifo_tuser),
    .pkt_fifo_tlast   (pkt_fifo_tlast),
    .pkt_fifo_empty   (pkt_fifo_empty),
    .pkt_fifo_rd_en   (pkt_fifo_rd_en),
    .fifo_count       (fifo_count),
    .pkt_count        (pkt_count),
    .fifo_almost_full (fifo_almost_full),
    .rd_underflow     (rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  seg_t ref_q[$];
  bit   uf_m  = 1'b0;
  bit   rdy_m = 1'b0;

  task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic seg_t rnd_seg(input bit last);
    seg_t s;
    s.last = last;
    s.user = {$urandom, $urandom, $urandom, $urandom};
    s.keep = $urandom;
    s.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return s;
  endfunction

  // Reference model: an ordered queue of stored segments. Outputs are checked
  // half a cycle after each edge; then the handshakes about to happen at the
  // next edge are applied to the model.
  always @(negedge clk) begin
    seg_t head, front;
    int   n, n_last;
    bit   acc;
    if (areset) begin
      ref_q.delete();
      uf_m  = 1'b0;
      rdy_m = 1'b0;
    end
    n = ref_q.size();
    n_last = 0;
    foreach (ref_q[i]) if (ref_q[i].last) n_last++;
    head = {pkt_fifo_tlast, pkt_fifo_tuser, pkt_fifo_tkeep, pkt_fifo_tdata};
    chk("tready", s_axis_tready, rdy_m && n < DEPTH);
    chk("empty", pkt_fifo_empty, n == 0);
    chk("fifo_count", fifo_count, n);
    chk("pkt_count", pkt_count, n_last);
    chk("almost_full", fifo_almost_full, n >= AFULL);
    chk("rd_underflow", rd_underflow, uf_m);
    if (n == 0) chk("head_idle_zero", head, '0);
    if (!areset) begin
      acc = s_axis_tvalid && rdy_m && n < DEPTH;
      if (pkt_fifo_rd_en) begin
        if (n == 0) uf_m = 1'b1;
        else begin
          front = ref_q.pop_front();
          chk("pop_data", head, front);
        end
      end else if (n != 0) begin
        chk("head_data", head, ref_q[0]);
      end
      if (acc) ref_q.push_back({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata});
      rdy_m = 1'b1;
    end
  end

  task automatic cyc(input bit v, input bit l, input bit r);
    seg_t s;
    s = rnd_seg(l);
    s_axis_tvalid  = v;
    s_axis_tlast   = s.last;
    s_axis_tuser   = s.user;
    s_axis_tkeep   = s.keep;
    s_axis_tdata   = s.data;
    pkt_fifo_rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) cyc(0, 0, 0);
    areset = 1'b0;
    cyc(0, 0, 0);
  endtask

  initial begin
    areset         = 1'b1;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tkeep   = '0;
    s_axis_tuser   = '0;
    pkt_fifo_rd_en = 1'b0;
    do_reset();

    // single 3-segment packet, then drain
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(0, 0, 0);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 0, 0);

    // fill to depth, hold tvalid against backpressure, pop one, refill
    repeat (DEPTH) cyc(1, 0, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (DEPTH) cyc(0, 0, 1);

    // steady push+pop at count 10
    repeat (10) cyc(1, 0, 0);
    repeat (100) cyc(1, $urandom_range(0, 3) == 0, 1);
    repeat (10) cyc(0, 0, 1);

    // underflow, then push+pop while empty
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    // mid-packet reset, then a fresh single-segment packet
    cyc(1, 0, 0); cyc(1, 0, 0);
    do_reset();
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    // random traffic with varying pressure on both sides
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 500; k++)
        cyc($urandom_range(0, 9) < 3 + 2 * ph, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7 - 2 * ph);
    end
    repeat (DEPTH + 2) cyc(0, 0, 1);
    cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
